// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB and decodes the instruction register into
// datapath mux selects, ALU op and write enables.
// Optional feature macro: MC_CTRL_INSTR_CNT_EN (retired-instruction counter).
module mc_ctrl #(
  parameter int unsigned ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      ext_op,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem_to_reg,
  output logic [1:0]      pc_src,
  output logic [ST_W-1:0] state,
  output logic [31:0]     instr_cnt
);

  typedef enum logic [ST_W-1:0] {
    StFetch   = ST_W'(0),
    StDecode  = ST_W'(1),
    StExecR   = ST_W'(2),
    StExecI   = ST_W'(3),
    StAluWb   = ST_W'(4),
    StMemAddr = ST_W'(5),
    StMemRd   = ST_W'(6),
    StMemWb   = ST_W'(7),
    StMemWr   = ST_W'(8),
    StBranch  = ST_W'(9),
    StJump    = ST_W'(10)
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;

  state_e     state_q, state_d;
  logic       retire;
  logic [5:0] opcode, funct;
  logic       is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

  assign opcode  = instr[31:26];
  assign funct   = instr[5:0];
  assign is_addu = (opcode == OpRtype) && (funct == FnAddu);
  assign is_subu = (opcode == OpRtype) && (funct == FnSubu);
  assign is_jr   = (opcode == OpRtype) && (funct == FnJr);
  assign is_ori  = (opcode == OpOri);
  assign is_lui  = (opcode == OpLui);
  assign is_lw   = (opcode == OpLw);
  assign is_sw   = (opcode == OpSw);
  assign is_beq  = (opcode == OpBeq);
  assign is_j    = (opcode == OpJ);
  assign is_jal  = (opcode == OpJal);

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode of (state, opcode, funct).
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    ext_op     = 2'b00;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    pc_src     = 2'b00;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (is_addu || is_subu) begin
          state_d = StExecR;
        end else if (is_ori || is_lui) begin
          state_d = StExecI;
        end else if (is_lw || is_sw) begin
          state_d = StMemAddr;
        end else if (is_beq) begin
          state_d = StBranch;
        end else if (is_j || is_jal || is_jr) begin
          state_d = StJump;
        end else begin
          // Illegal: drop it without any write strobe or retire count.
          state_d = StFetch;
        end
      end
      StExecR: begin
        alu_op  = is_subu ? 2'b01 : 2'b00;
        state_d = StAluWb;
      end
      StExecI: begin
        alu_src_b = 2'b01;
        if (is_ori) begin
          alu_op = 2'b10;
          ext_op = 2'b00;
        end else begin
          // lui: rs is $0, so add of imm<<16 yields the upper immediate.
          alu_op = 2'b00;
          ext_op = 2'b10;
        end
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OpRtype) ? 2'b01 : 2'b00;
        state_d   = StFetch;
        retire    = 1'b1;
      end
      StMemAddr: begin
        alu_src_b = 2'b01;
        ext_op    = 2'b01;
        state_d   = is_lw ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = StFetch;
        retire     = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StBranch: begin
        alu_op   = 2'b01;
        pc_src   = 2'b01;
        pc_write = zero;
        state_d  = StFetch;
        retire   = 1'b1;
      end
      StJump: begin
        pc_write = 1'b1;
        pc_src   = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        state_d = StFetch;
        retire  = 1'b1;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
    // No strobe may fire while reset is held.
    if (!rst_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state = state_q;

`ifdef MC_CTRL_INSTR_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Retired-instruction count; wraps naturally at 32 bits.
  always_comb begin
    cnt_d = retire ? (cnt_q + 32'd1) : cnt_q;
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

  // Register fields and retire are not needed in every build.
  logic unused_bits;
  assign unused_bits = ^{instr[25:6], retire};

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: table of instruction vectors with expected
// per-instruction observations, compared via a scoreboard queue, plus reset
// corner-case sequences.
module tb_mc_ctrl;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;

`ifdef MC_CTRL_INSTR_CNT_EN
  localparam logic CNT_EN = 1'b1;
`else
  localparam logic CNT_EN = 1'b0;
`endif

  logic        clk, rst_n, zero, mem_ready;
  logic [31:0] instr;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write;
  logic [1:0]  alu_src_b, alu_op, ext_op, reg_dst, mem_to_reg, pc_src;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  int n_chk = 0;
  int n_err = 0;

  mc_ctrl #(.ST_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .ext_op     (ext_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .state      (state),
    .instr_cnt  (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    int          f_stall;
    int          m_stall;
    int          cycles;
    int          rw_cyc;
    logic [1:0]  rw_dst;
    logic [1:0]  rw_m2r;
    int          pw_cyc;
    logic [1:0]  pw_src;
    int          mw_n;
    logic        chk3;
    logic [3:0]  st3;
    logic [1:0]  alu3;
    logic [1:0]  ext3;
    logic [1:0]  srcb3;
    logic        retire;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];
  vec_t exp_q[$];

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: actual=%0h expected=%0h", tag, name, act, exp);
    end
  endtask

  // Drive one instruction from its first FETCH cycle until the next FETCH.
  task automatic run_vec(input vec_t v);
    int cyc, fst, mst, irw, rwn, rwc, pwc, mwn;
    logic [1:0] rwd, rwm, psrc, a3, e3, b3;
    logic [3:0] s3;
    logic seen, timeout;
    logic [31:0] cnt0;
    vec_t e;
    cyc = 0; fst = 0; mst = 0; irw = 0; rwn = 0; rwc = 0; pwc = 0; mwn = 0;
    rwd = 2'b00; rwm = 2'b00; psrc = 2'b00; a3 = 2'b00; e3 = 2'b00; b3 = 2'b00;
    s3 = 4'd0; seen = 1'b0; timeout = 1'b0;
    instr = v.instr;
    zero  = v.zero;
    exp_q.push_back(v);
    cnt0 = instr_cnt;
    while (1) begin
      if (seen && state == S_FETCH) break;
      if (cyc >= 40) begin
        timeout = 1'b1;
        break;
      end
      cyc++;
      case (state)
        S_FETCH: begin
          mem_ready = (fst >= v.f_stall);
          fst++;
        end
        S_MEM_RD, S_MEM_WR: begin
          mem_ready = (mst >= v.m_stall);
          mst++;
        end
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (state != S_FETCH) seen = 1'b1;
      if (ir_write) irw++;
      if (reg_write) begin
        rwn++;
        rwc = cyc;
        rwd = reg_dst;
        rwm = mem_to_reg;
      end
      if (pc_write && state != S_FETCH) begin
        pwc  = cyc;
        psrc = pc_src;
      end
      if (mem_write) mwn++;
      if (cyc == 3) begin
        s3 = state; a3 = alu_op; e3 = ext_op; b3 = alu_src_b;
      end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    chk(e.name, "timeout", 32'(timeout), 32'd0);
    chk(e.name, "cycles", 32'(cyc), 32'(e.cycles));
    chk(e.name, "ir_write_pulses", 32'(irw), 32'd1);
    chk(e.name, "reg_write_n", 32'(rwn), (e.rw_cyc != 0) ? 32'd1 : 32'd0);
    chk(e.name, "reg_write_cyc", 32'(rwc), 32'(e.rw_cyc));
    chk(e.name, "reg_dst", 32'(rwd), 32'(e.rw_dst));
    chk(e.name, "mem_to_reg", 32'(rwm), 32'(e.rw_m2r));
    chk(e.name, "pc_write_cyc", 32'(pwc), 32'(e.pw_cyc));
    chk(e.name, "pc_src", 32'(psrc), 32'(e.pw_src));
    chk(e.name, "mem_write_n", 32'(mwn), 32'(e.mw_n));
    if (e.chk3) begin
      chk(e.name, "state_c3", 32'(s3), 32'(e.st3));
      chk(e.name, "alu_op_c3", 32'(a3), 32'(e.alu3));
      chk(e.name, "ext_op_c3", 32'(e3), 32'(e.ext3));
      chk(e.name, "alu_src_b_c3", 32'(b3), 32'(e.srcb3));
    end
    chk(e.name, "cnt_delta", instr_cnt - cnt0, (CNT_EN && e.retire) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"addu", 32'h00221821, 1'b0, 0, 0, 4, 4, 2'b01, 2'b00, 0, 2'b00, 0,
                 1'b1, S_EXEC_R, 2'b00, 2'b00, 2'b00, 1'b1};
    vecs[1]  = '{"subu", 32'h00221823, 1'b0, 0, 0, 4, 4, 2'b01, 2'b00, 0, 2'b00, 0,
                 1'b1, S_EXEC_R, 2'b01, 2'b00, 2'b00, 1'b1};
    vecs[2]  = '{"ori", 32'h342200ff, 1'b0, 0, 0, 4, 4, 2'b00, 2'b00, 0, 2'b00, 0,
                 1'b1, S_EXEC_I, 2'b10, 2'b00, 2'b01, 1'b1};
    vecs[3]  = '{"lui", 32'h3c011234, 1'b0, 0, 0, 4, 4, 2'b00, 2'b00, 0, 2'b00, 0,
                 1'b1, S_EXEC_I, 2'b00, 2'b10, 2'b01, 1'b1};
    vecs[4]  = '{"lw_stall", 32'h8c230004, 1'b0, 3, 2, 10, 10, 2'b00, 2'b01, 0, 2'b00, 0,
                 1'b1, S_FETCH, 2'b00, 2'b00, 2'b10, 1'b1};
    vecs[5]  = '{"lw", 32'h8c230004, 1'b0, 0, 0, 5, 5, 2'b00, 2'b01, 0, 2'b00, 0,
                 1'b1, S_MEM_ADDR, 2'b00, 2'b01, 2'b01, 1'b1};
    vecs[6]  = '{"sw_mstall", 32'hac230004, 1'b0, 0, 1, 5, 0, 2'b00, 2'b00, 0, 2'b00, 2,
                 1'b1, S_MEM_ADDR, 2'b00, 2'b01, 2'b01, 1'b1};
    vecs[7]  = '{"beq_taken", 32'h10220003, 1'b1, 0, 0, 3, 0, 2'b00, 2'b00, 3, 2'b01, 0,
                 1'b1, S_BRANCH, 2'b01, 2'b00, 2'b00, 1'b1};
    vecs[8]  = '{"beq_not", 32'h10220003, 1'b0, 0, 0, 3, 0, 2'b00, 2'b00, 0, 2'b00, 0,
                 1'b1, S_BRANCH, 2'b01, 2'b00, 2'b00, 1'b1};
    vecs[9]  = '{"jal", 32'h0c000010, 1'b0, 0, 0, 3, 3, 2'b10, 2'b10, 3, 2'b10, 0,
                 1'b1, S_JUMP, 2'b00, 2'b00, 2'b00, 1'b1};
    vecs[10] = '{"j", 32'h08000010, 1'b0, 0, 0, 3, 0, 2'b00, 2'b00, 3, 2'b10, 0,
                 1'b1, S_JUMP, 2'b00, 2'b00, 2'b00, 1'b1};
    vecs[11] = '{"jr", 32'h03e00008, 1'b1, 0, 0, 3, 0, 2'b00, 2'b00, 3, 2'b11, 0,
                 1'b1, S_JUMP, 2'b00, 2'b00, 2'b00, 1'b1};
    vecs[12] = '{"illegal_op", 32'hfc000000, 1'b1, 0, 0, 2, 0, 2'b00, 2'b00, 0, 2'b00, 0,
                 1'b0, S_FETCH, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[13] = '{"illegal_fn", 32'h0000003f, 1'b1, 0, 0, 2, 0, 2'b00, 2'b00, 0, 2'b00, 0,
                 1'b0, S_FETCH, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[14] = '{"sw_fstall", 32'hac230004, 1'b0, 2, 0, 6, 0, 2'b00, 2'b00, 0, 2'b00, 1,
                 1'b1, S_FETCH, 2'b00, 2'b00, 2'b10, 1'b1};

    // Reset: FETCH, no enables even with mem_ready high, counter clear.
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; instr = 32'h00221821;
    @(negedge clk);
    @(negedge clk);
    chk("reset", "state", 32'(state), 32'(S_FETCH));
    chk("reset", "mem_read", 32'(mem_read), 32'd0);
    chk("reset", "ir_write", 32'(ir_write), 32'd0);
    chk("reset", "pc_write", 32'(pc_write), 32'd0);
    chk("reset", "instr_cnt", instr_cnt, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_rel", "mem_read", 32'(mem_read), 32'd1);
    chk("reset_rel", "alu_src_b", 32'(alu_src_b), 32'd2);
    @(negedge clk);
    chk("reset_rel", "state", 32'(state), 32'(S_DECODE));
    // Let that instruction finish so the table starts from a clean FETCH.
    mem_ready = 1'b1;
    for (int k = 0; k < 20 && state != S_FETCH; k++) @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Reset asserted mid-MEM_WR of sw: aborts asynchronously, nothing retires.
    instr = 32'hac230004;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sw_reset", "state_pre", 32'(state), 32'(S_MEM_WR));
    chk("sw_reset", "mem_write_pre", 32'(mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("sw_reset", "state", 32'(state), 32'(S_FETCH));
    chk("sw_reset", "mem_write", 32'(mem_write), 32'd0);
    chk("sw_reset", "reg_write", 32'(reg_write), 32'd0);
    chk("sw_reset", "ir_write", 32'(ir_write), 32'd0);
    chk("sw_reset", "instr_cnt", instr_cnt, 32'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("sw_reset", "held_state", 32'(state), 32'(S_FETCH));
    chk("sw_reset", "held_cnt", instr_cnt, 32'd0);
    rst_n = 1'b1;
    run_vec(vecs[0]);
    chk("sw_reset", "cnt_after", instr_cnt, CNT_EN ? 32'd1 : 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
